// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: count requests in, count and decoded flags out.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             incr;
    logic             decr;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] q;
    logic             at_max;
    logic             at_zero;
    logic             bnd;
    logic             match;

    modport master (
        output clr, load, load_val, incr, decr, cmp_val,
        input  q, at_max, at_zero, bnd, match
    );

    modport slave (
        input  clr, load, load_val, incr, decr, cmp_val,
        output q, at_max, at_zero, bnd, match
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate, clear, clamped load,
// boundary flags, a registered boundary-event pulse and a compare-match decode.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    updown_mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2
    } op_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             bnd_q, bnd_d;
    op_e              op;

    always_comb begin
        op = OP_HOLD;
        if (bus.incr && !bus.decr) begin
            op = OP_UP;
        end else if (bus.decr && !bus.incr) begin
            op = OP_DOWN;
        end
    end

    // Priority below reset: clear, then load, then the count step.
    always_comb begin
        q_d   = q_q;
        bnd_d = 1'b0;
        if (bus.clr) begin
            q_d = '0;
        end else if (bus.load) begin
            q_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
        end else begin
            unique case (op)
                OP_UP: begin
                    if (q_q == MAX_W) begin
                        bnd_d = 1'b1;
                        q_d   = SATURATE ? q_q : '0;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
                OP_DOWN: begin
                    if (q_q == '0) begin
                        bnd_d = 1'b1;
                        q_d   = SATURATE ? q_q : MAX_W;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                default: begin
                    q_d   = q_q;
                    bnd_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= '0;
            bnd_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            bnd_q <= bnd_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.bnd     = bnd_q;
    assign bus.at_max  = (q_q == MAX_W);
    assign bus.at_zero = (q_q == '0);
    assign bus.match   = (q_q == bus.cmp_val);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Random and directed stimulus for three counter configurations, compared against an arithmetic model.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, incr, decr;
    logic [7:0] load_val, cmp_val;

    int n_chk = 0;
    int n_err = 0;

    // Model state per configuration: w = wrap MAX 9, s = saturate MAX 9, f = 4-bit full range wrap.
    int m_w, m_s, m_f;
    int b_w, b_s, b_f;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(8)) if_w ();
    updown_mod_counter_if #(.WIDTH(8)) if_s ();
    updown_mod_counter_if #(.WIDTH(4)) if_f ();

    assign if_w.clr = clr;  assign if_w.load = load;  assign if_w.load_val = load_val;
    assign if_w.incr = incr; assign if_w.decr = decr; assign if_w.cmp_val = cmp_val;
    assign if_s.clr = clr;  assign if_s.load = load;  assign if_s.load_val = load_val;
    assign if_s.incr = incr; assign if_s.decr = decr; assign if_s.cmp_val = cmp_val;
    assign if_f.clr = clr;  assign if_f.load = load;  assign if_f.load_val = load_val[3:0];
    assign if_f.incr = incr; assign if_f.decr = decr; assign if_f.cmp_val = cmp_val[3:0];

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(if_w.slave));
    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .bus(if_f.slave));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Count modulo (maxv+1) on wrap; pin to the end on saturate.
    task automatic model_step(inout int m, inout int b, input int maxv, input bit sat, input int lv);
        if (!rst_n || clr) begin
            m = 0; b = 0;
        end else if (load) begin
            m = (lv > maxv) ? maxv : lv; b = 0;
        end else if (incr && !decr) begin
            b = (m == maxv) ? 1 : 0;
            if (sat) m = (m == maxv) ? m : m + 1;
            else     m = (m + 1) % (maxv + 1);
        end else if (decr && !incr) begin
            b = (m == 0) ? 1 : 0;
            if (sat) m = (m == 0) ? 0 : m - 1;
            else     m = (m + maxv) % (maxv + 1);
        end else begin
            b = 0;
        end
    endtask

    task automatic check_one(input string p, input int q, input int am, input int az,
                             input int bn, input int mt, input int m, input int b,
                             input int maxv, input int cv);
        chk({p, "_q"},       q,  m);
        chk({p, "_at_max"},  am, (m == maxv) ? 1 : 0);
        chk({p, "_at_zero"}, az, (m == 0) ? 1 : 0);
        chk({p, "_bnd"},     bn, b);
        chk({p, "_match"},   mt, (m == cv) ? 1 : 0);
    endtask

    task automatic check_all();
        check_one("w", int'(if_w.q), int'(if_w.at_max), int'(if_w.at_zero), int'(if_w.bnd),
                  int'(if_w.match), m_w, b_w, 9, int'(cmp_val));
        check_one("s", int'(if_s.q), int'(if_s.at_max), int'(if_s.at_zero), int'(if_s.bnd),
                  int'(if_s.match), m_s, b_s, 9, int'(cmp_val));
        check_one("f", int'(if_f.q), int'(if_f.at_max), int'(if_f.at_zero), int'(if_f.bnd),
                  int'(if_f.match), m_f, b_f, 15, int'(cmp_val[3:0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(m_w, b_w, 9,  1'b0, int'(load_val));
        model_step(m_s, b_s, 9,  1'b1, int'(load_val));
        model_step(m_f, b_f, 15, 1'b0, int'(load_val[3:0]));
        #1;
        check_all();
    endtask

    task automatic set_in(input bit c, input bit l, input int lv, input bit i, input bit d);
        clr = c; load = l; load_val = 8'(lv); incr = i; decr = d;
    endtask

    initial begin
        m_w = 0; m_s = 0; m_f = 0; b_w = 0; b_s = 0; b_f = 0;
        rst_n = 1'b0; cmp_val = 8'd0;
        set_in(0, 0, 0, 0, 0);

        // Reset state
        tick(); tick();
        chk("rst_q", int'(if_w.q), 0);
        chk("rst_at_zero", int'(if_w.at_zero), 1);
        chk("rst_bnd", int'(if_w.bnd), 0);
        chk("rst_match", int'(if_w.match), 1);
        rst_n = 1'b1;

        // Up-count through the wrap
        set_in(0, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++) tick();
        chk("up_at9_q", int'(if_w.q), 9);
        chk("up_at9_at_max", int'(if_w.at_max), 1);
        tick();
        chk("up_wrap_q", int'(if_w.q), 0);
        chk("up_wrap_bnd", int'(if_w.bnd), 1);

        // Down wrap then three more steps
        set_in(0, 0, 0, 0, 1);
        tick();
        chk("dn_wrap_q", int'(if_w.q), 9);
        chk("dn_wrap_bnd", int'(if_w.bnd), 1);
        tick(); tick(); tick();
        chk("dn3_q", int'(if_w.q), 6);
        chk("dn3_bnd", int'(if_w.bnd), 0);

        // Saturation at both ends
        set_in(0, 1, 8, 0, 0); tick();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hi_q", int'(if_s.q), 9);
        chk("sat_hi_bnd", int'(if_s.bnd), 1);
        set_in(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) tick();
        chk("sat_lo_q", int'(if_s.q), 0);
        chk("sat_lo_bnd", int'(if_s.bnd), 1);

        // Priority: clr > load > count
        set_in(0, 1, 5, 0, 0); tick();
        set_in(1, 1, 7, 1, 0); tick();
        chk("prio_clr_q", int'(if_w.q), 0);
        set_in(0, 1, 7, 1, 0); tick();
        chk("prio_load_q", int'(if_w.q), 7);
        set_in(0, 0, 0, 1, 1); tick();
        chk("prio_both_q", int'(if_w.q), 7);
        chk("prio_both_bnd", int'(if_w.bnd), 0);

        // Load clamp and combinational match
        set_in(0, 1, 200, 0, 0); tick();
        chk("clamp_q", int'(if_w.q), 9);
        chk("clamp_at_max", int'(if_w.at_max), 1);
        set_in(0, 0, 0, 0, 0);
        cmp_val = 8'd9; #1;
        chk("match_hi", int'(if_w.match), 1);
        check_all();
        cmp_val = 8'd3; #1;
        chk("match_lo", int'(if_w.match), 0);
        check_all();

        // Reset mid-count
        set_in(1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0; tick();
        chk("midrst_q", int'(if_w.q), 0);
        chk("midrst_bnd", int'(if_w.bnd), 0);
        rst_n = 1'b1; tick();
        chk("resume1_q", int'(if_w.q), 1);
        tick();
        chk("resume2_q", int'(if_w.q), 2);
        chk("resume2_bnd", int'(if_w.bnd), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 8'($urandom_range(0, 255));
            incr     = 1'($urandom_range(0, 1));
            decr     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cmp_val = 8'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised up/down counter. It generalises the team's fixed 8-bit increment-only counter with these additions:
- configurable width and modulus
- wrap or saturate mode
- synchronous clear and parallel load
- boundary flags and a one-cycle boundary-event pulse
- a compare-match output

It sits in the datapath as the general event/tick counter feeding FSMs and display logic.

Parameters:
WIDTH, 8, bit width of the count register and of load_val and cmp_val.
MAX_VAL, 255, terminal count; legal count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst_n  input  1  reset; synchronous, active-low.
clr  input  1  synchronous clear to 0, active-high.
load  input  1  parallel load strobe, active-high.
load_val  input  WIDTH  value captured on load.
incr  input  1  count-up request for this cycle.
decr  input  1  count-down request for this cycle.
cmp_val  input  WIDTH  compare value for match.
q  output  WIDTH  current count, registered.
at_max  output  1  high while q == MAX_VAL.
at_zero  output  1  high while q == 0.
bnd  output  1  registered one-cycle pulse on a boundary event.
match  output  1  high while q == cmp_val.

Behaviour:
- All state updates on the rising edge of clk. The only state is q and bnd.
- Reset: when rst_n is sampled low, q <= 0 and bnd <= 0.
  - Flags are derived from q, so immediately after reset at_zero = 1, at_max = 0, and match = (cmp_val == 0).
  - Reset overrides every other input, including mid-count or mid-load.
- Per-edge priority, highest first: reset, clr, load, count.
- clr = 1: q <= 0, bnd <= 0. load, incr and decr are ignored that cycle.
- load = 1, clr = 0:
  - q <= load_val if load_val <= MAX_VAL, else q <= MAX_VAL (clamped).
  - bnd <= 0. incr and decr are ignored.
- Count decode, when clr = 0 and load = 0:
  - incr & ~decr: up step.
  - decr & ~incr: down step.
  - Both high or both low: q holds, bnd <= 0.
- Up step:
  - If q < MAX_VAL: q <= q + 1, bnd <= 0.
  - If q == MAX_VAL and SATURATE = 0: q <= 0, bnd <= 1.
  - If q == MAX_VAL and SATURATE = 1: q holds, bnd <= 1.
- Down step:
  - If q > 0: q <= q - 1, bnd <= 0.
  - If q == 0 and SATURATE = 0: q <= MAX_VAL, bnd <= 1.
  - If q == 0 and SATURATE = 1: q holds, bnd <= 1.
- Boundary pulse timing:
  - bnd is high for exactly the one cycle following the boundary edge.
  - A request held at the boundary in saturate mode re-asserts bnd every cycle.
- Arithmetic is unsigned and compares use WIDTH bits. With MAX_VAL < 2^WIDTH-1, q never exceeds MAX_VAL; no state holds an illegal value.
- Flag timing: at_max, at_zero and match are combinational decodes of registered q (and of cmp_val for match). They change in the same cycle as q, with zero added latency.
- Latency: one clock from request to q update. No pipelining, no handshake; the block can take a request every cycle.

Test Plan:
- Reset and up-count (WIDTH=8, MAX_VAL=9, SATURATE=0): hold rst_n=0 for 2 cycles -> q=0, at_zero=1, bnd=0. Pulse incr for 10 cycles -> q steps 1..9, then 0. bnd is high only the cycle q returns to 0; at_max is high while q=9.
- Down wrap (MAX_VAL=9, SATURATE=0): from q=0 pulse decr once -> q=9, bnd=1 for one cycle. Three more decr -> q=6, bnd=0.
- Saturate (MAX_VAL=9, SATURATE=1): load 8, then incr held for 4 cycles -> q=9,9,9,9; bnd=0,1,1,1 on successive cycles. Then decr held at q=0 -> q stays 0 and bnd stays 1.
- Priority: at q=5, set clr=1, load=1, load_val=7, incr=1 together -> q=0. Next cycle load=1 with incr=1 -> q=7. Next cycle incr=decr=1 -> q stays 7, bnd=0.
- Load clamp: MAX_VAL=9, load_val=200 -> q=9, at_max=1. Set cmp_val=9 -> match=1; set cmp_val=3 -> match=0 in the same cycle.
- Reset mid-operation: incr held continuously; drop rst_n for one cycle at q=4 -> q=0 on that edge. Counting resumes 1, 2, … once rst_n=1; no stale bnd pulse appears.
